// File: rtl/nw_vc_freepool_allocator.sv
// rtl/nw_vc_freepool_allocator.sv - free-pool VC allocator with per-output-port round-robin arbitration
module nw_vc_freepool_allocator #(
  parameter int np                        = 5,
  parameter int nv                        = 4,
  parameter int ALLOCS_PER_PORT           = 1,
  parameter int dynamic_priority_vc_alloc = 0,
  parameter int PRI_W                     = 2,
  parameter int LNV                       = (nv > 1) ? $clog2(nv) : 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [np-1:0][nv-1:0]                         req_i,
  input  logic [np-1:0][nv-1:0][np-1:0]                 output_port_i,
  input  logic [np-1:0][nv-1:0][PRI_W-1:0]              req_priority_i,
  input  logic [np-1:0][ALLOCS_PER_PORT-1:0]            rel_valid_i,
  input  logic [np-1:0][ALLOCS_PER_PORT-1:0][LNV-1:0]   rel_vc_i,
  output logic [np-1:0][nv-1:0][LNV-1:0]                vc_new_o,
  output logic [np-1:0][nv-1:0]                         vc_new_valid_o,
  output logic [np-1:0][LNV:0]                          free_count_o,
  output logic [np-1:0]                                 no_free_vc_o,
  output logic                                          err_release_o
);
  localparam int NF = np * nv;
  localparam int IW = (NF > 1) ? $clog2(NF) : 1;
  localparam int A  = ALLOCS_PER_PORT;

  logic [np-1:0][nv-1:0][LNV-1:0] pool_q, pool_d;
  logic [np-1:0][LNV-1:0]         head_q, head_d;
  logic [np-1:0][LNV-1:0]         tail_q, tail_d;
  logic [np-1:0][LNV:0]           cnt_q, cnt_d;
  logic [np-1:0][IW-1:0]          rr_q, rr_d;
  logic [np-1:0][nv-1:0][LNV-1:0] vc_new_q, vc_new_d;
  logic [np-1:0][nv-1:0]          valid_q, valid_d;
  logic                           err_q, err_d;

  logic [NF-1:0]    elig [np];
  logic [PRI_W-1:0] pri_f [NF];

  // Flatten requests per output port; a VC granted last cycle is still pending (valid_q) and sits out.
  always_comb begin
    for (int p = 0; p < np; p++) begin
      elig[p] = '0;
      for (int i = 0; i < np; i++)
        for (int v = 0; v < nv; v++)
          elig[p][i*nv+v] = req_i[i][v] && $onehot(output_port_i[i][v]) &&
                            output_port_i[i][v][p] && !valid_q[i][v];
    end
    for (int i = 0; i < np; i++)
      for (int v = 0; v < nv; v++)
        pri_f[i*nv+v] = req_priority_i[i][v];
  end

  // Per port: pick up to A winners in RR order (highest priority class first in dynamic mode),
  // pop the pool for them, then push releases at the tail, dropping any that would overfill it.
  always_comb begin
    logic [NF-1:0]    left;
    logic [PRI_W-1:0] maxp;
    logic [LNV-1:0]   gvc;
    int               k, last, acc, tl, win, best_d, d, hd;
    pool_d   = pool_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    vc_new_d = vc_new_q;
    valid_d  = '0;
    err_d    = err_q;
    left = '0; maxp = '0; gvc = '0;
    k = 0; last = 0; acc = 0; tl = 0; win = 0; best_d = 0; d = 0; hd = 0;
    for (int p = 0; p < np; p++) begin
      left = elig[p];
      k    = 0;
      last = 0;
      for (int j = 0; j < A; j++) begin
        maxp = '0;
        if (dynamic_priority_vc_alloc != 0)
          for (int n = 0; n < NF; n++)
            if (left[n] && pri_f[n] > maxp) maxp = pri_f[n];
        best_d = NF;
        win    = 0;
        for (int n = 0; n < NF; n++) begin
          d = (n + NF - int'(rr_q[p])) % NF;
          if (left[n] && (dynamic_priority_vc_alloc == 0 || pri_f[n] == maxp) && d < best_d) begin
            best_d = d;
            win    = n;
          end
        end
        // Only entries present at the start of the cycle are grantable: no release bypass.
        if (best_d < NF && j < int'(cnt_q[p])) begin
          hd  = (int'(head_q[p]) + j) % nv;
          gvc = '0;
          for (int e = 0; e < nv; e++)
            if (e == hd) gvc = pool_q[p][e];
          for (int n = 0; n < NF; n++)
            if (n == win) begin
              left[n]                = 1'b0;
              valid_d[n/nv][n%nv]    = 1'b1;
              vc_new_d[n/nv][n%nv]   = gvc;
            end
          k    = k + 1;
          last = win;
        end
      end
      if (k > 0) begin
        head_d[p] = LNV'((int'(head_q[p]) + k) % nv);
        rr_d[p]   = IW'((last + 1) % NF);
      end
      acc = int'(cnt_q[p]) - k;
      tl  = int'(tail_q[p]);
      for (int s = 0; s < A; s++) begin
        if (rel_valid_i[p][s]) begin
          if (acc < nv) begin
            for (int e = 0; e < nv; e++)
              if (e == tl) pool_d[p][e] = rel_vc_i[p][s];
            tl  = (tl + 1) % nv;
            acc = acc + 1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      tail_d[p] = LNV'(tl);
      cnt_d[p]  = (LNV+1)'(acc);
    end
  end

  // State and registered outputs; reset refills every pool with VCs 0..nv-1 in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < np; p++) begin
        for (int e = 0; e < nv; e++) pool_q[p][e] <= LNV'(e);
        cnt_q[p] <= (LNV+1)'(nv);
      end
      head_q   <= '0;
      tail_q   <= '0;
      rr_q     <= '0;
      vc_new_q <= '0;
      valid_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      pool_q   <= pool_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      vc_new_q <= vc_new_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign vc_new_o       = vc_new_q;
  assign vc_new_valid_o = valid_q;
  assign free_count_o   = cnt_q;
  assign err_release_o  = err_q;
  always_comb for (int p = 0; p < np; p++) no_free_vc_o[p] = (cnt_q[p] == '0);

endmodule

// File: tb/tb_nw_vc_freepool_allocator.sv
// tb/tb_nw_vc_freepool_allocator.sv - self-checking bench for nw_vc_freepool_allocator
module tb_nw_vc_freepool_allocator;
  localparam int NP = 5, NV = 4, LNV = 2, PW = 2, NF = NP * NV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  int   n_chk = 0, n_err = 0;
  int   cur_A = 1, cur_dyn = 0;

  logic [NP-1:0][NV-1:0]          in_req;
  logic [NP-1:0][NV-1:0][NP-1:0]  in_port;
  logic [NP-1:0][NV-1:0][PW-1:0]  in_pri;
  logic [NP-1:0][1:0]             in_relv;
  logic [NP-1:0][1:0][LNV-1:0]    in_relvc;

  logic [NP-1:0][NV-1:0]          req_a, req_b, valid_a, valid_b, out_valid;
  logic [NP-1:0][0:0]             relv_a;
  logic [NP-1:0][0:0][LNV-1:0]    relvc_a;
  logic [NP-1:0][1:0]             relv_b;
  logic [NP-1:0][1:0][LNV-1:0]    relvc_b;
  logic [NP-1:0][NV-1:0][LNV-1:0] vcnew_a, vcnew_b, out_vcnew;
  logic [NP-1:0][LNV:0]           cnt_a, cnt_b, out_cnt;
  logic [NP-1:0]                  nf_a, nf_b, out_nf;
  logic                           err_a, err_b, out_err;

  assign req_a   = sel ? '0 : in_req;
  assign req_b   = sel ? in_req : '0;
  assign relv_b  = sel ? in_relv : '0;
  assign relvc_b = in_relvc;
  always_comb
    for (int p = 0; p < NP; p++) begin
      relv_a[p][0]  = !sel && in_relv[p][0];
      relvc_a[p][0] = in_relvc[p][0];
    end
  assign out_valid = sel ? valid_b : valid_a;
  assign out_vcnew = sel ? vcnew_b : vcnew_a;
  assign out_cnt   = sel ? cnt_b   : cnt_a;
  assign out_nf    = sel ? nf_b    : nf_a;
  assign out_err   = sel ? err_b   : err_a;

  nw_vc_freepool_allocator #(.np(NP), .nv(NV), .ALLOCS_PER_PORT(1), .dynamic_priority_vc_alloc(0), .PRI_W(PW))
  dut_a (.clk(clk), .rst(rst), .req_i(req_a), .output_port_i(in_port), .req_priority_i(in_pri),
         .rel_valid_i(relv_a), .rel_vc_i(relvc_a), .vc_new_o(vcnew_a), .vc_new_valid_o(valid_a),
         .free_count_o(cnt_a), .no_free_vc_o(nf_a), .err_release_o(err_a));

  nw_vc_freepool_allocator #(.np(NP), .nv(NV), .ALLOCS_PER_PORT(2), .dynamic_priority_vc_alloc(1), .PRI_W(PW))
  dut_b (.clk(clk), .rst(rst), .req_i(req_b), .output_port_i(in_port), .req_priority_i(in_pri),
         .rel_valid_i(relv_b), .rel_vc_i(relvc_b), .vc_new_o(vcnew_b), .vc_new_valid_o(valid_b),
         .free_count_o(cnt_b), .no_free_vc_o(nf_b), .err_release_o(err_b));

  always #5 clk = ~clk;

  // Reference model: free lists as queues, candidates ordered by RR distance then priority.
  int                             m_pool [NP][$];
  int                             outst  [NP][$];
  int                             m_rr   [NP];
  logic [NP-1:0][NV-1:0]          m_pend;
  logic [NP-1:0][NV-1:0][LNV-1:0] m_vcnew;
  logic                           m_err;

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_pool[p].delete();
      outst[p].delete();
      for (int e = 0; e < NV; e++) m_pool[p].push_back(e);
      m_rr[p] = 0;
    end
    m_pend  = '0;
    m_vcnew = '0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    int cand[$];
    int k, n, t;
    logic [NP-1:0][NV-1:0] g;
    g = '0;
    for (int p = 0; p < NP; p++) begin
      cand.delete();
      for (int o = 0; o < NF; o++) begin
        n = (m_rr[p] + o) % NF;
        if (in_req[n/NV][n%NV] && $onehot(in_port[n/NV][n%NV]) && in_port[n/NV][n%NV][p] && !m_pend[n/NV][n%NV])
          cand.push_back(n);
      end
      if (cur_dyn != 0)
        for (int a = 1; a < cand.size(); a++) begin
          int b = a;
          while (b > 0 && in_pri[cand[b]/NV][cand[b]%NV] > in_pri[cand[b-1]/NV][cand[b-1]%NV]) begin
            t = cand[b]; cand[b] = cand[b-1]; cand[b-1] = t; b--;
          end
        end
      k = cur_A;
      if (m_pool[p].size() < k) k = m_pool[p].size();
      if (cand.size() < k) k = cand.size();
      for (int j = 0; j < k; j++) begin
        n = cand[j];
        t = m_pool[p].pop_front();
        m_vcnew[n/NV][n%NV] = LNV'(t);
        g[n/NV][n%NV] = 1'b1;
        outst[p].push_back(t);
      end
      if (k > 0) m_rr[p] = (cand[k-1] + 1) % NF;
    end
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < cur_A; s++)
        if (in_relv[p][s]) begin
          if (m_pool[p].size() < NV) m_pool[p].push_back(int'(in_relvc[p][s]));
          else m_err = 1'b1;
        end
    m_pend = g;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    in_req = '0; in_port = '0; in_pri = '0; in_relv = '0; in_relvc = '0;
  endtask

  task automatic do_reset(logic db);
    sel = db;
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic             do_rst;
    logic             dut_b;
    logic [NF-1:0]    req;
    logic [NP-1:0]    pvec;
    logic [NF-1:0][PW-1:0] pri;
    int               cport;
    logic [1:0]       relv;
    int               relvc0, relvc1;
    logic [NF-1:0]    exp_valid;
    int               exp_vc0, exp_vc1;
    int               exp_cnt;
    logic             exp_err;
  } vec_t;

  function automatic vec_t mk(logic rs, logic db, logic [NF-1:0] rq, logic [NP-1:0] pv, int cp,
                              logic [1:0] rv, int r0, int r1, logic [NF-1:0] ev, int v0, int v1,
                              int ec, logic ee);
    vec_t r;
    r.do_rst = rs; r.dut_b = db; r.req = rq; r.pvec = pv; r.pri = '0; r.cport = cp;
    r.relv = rv; r.relvc0 = r0; r.relvc1 = r1; r.exp_valid = ev; r.exp_vc0 = v0; r.exp_vc1 = v1;
    r.exp_cnt = ec; r.exp_err = ee;
    return r;
  endfunction

  task automatic apply_row(vec_t r, int idx);
    int j;
    if (r.do_rst) do_reset(r.dut_b);
    sel = r.dut_b;
    clear_inputs();
    for (int n = 0; n < NF; n++)
      if (r.req[n]) begin
        in_req[n/NV][n%NV]  = 1'b1;
        in_port[n/NV][n%NV] = r.pvec;
        in_pri[n/NV][n%NV]  = r.pri[n];
      end
    in_relv[r.cport]     = r.relv;
    in_relvc[r.cport][0] = LNV'(r.relvc0);
    in_relvc[r.cport][1] = LNV'(r.relvc1);
    @(posedge clk);
    #1;
    chk($sformatf("row%0d valid", idx), out_valid, r.exp_valid);
    j = 0;
    for (int n = 0; n < NF; n++)
      if (r.exp_valid[n]) begin
        chk($sformatf("row%0d vc_new[%0d]", idx, n), out_vcnew[n/NV][n%NV], (j == 0) ? r.exp_vc0 : r.exp_vc1);
        j++;
      end
    chk($sformatf("row%0d free_count", idx), out_cnt[r.cport], r.exp_cnt);
    chk($sformatf("row%0d no_free_vc", idx), out_nf[r.cport], (r.exp_cnt == 0));
    chk($sformatf("row%0d err_release", idx), out_err, r.exp_err);
    clear_inputs();
  endtask

  task automatic run_random(logic db, int ncyc);
    logic [NP-1:0][LNV:0] ecnt;
    logic [NP-1:0]        enf;
    int                   r;
    do_reset(db);
    cur_A   = db ? 2 : 1;
    cur_dyn = db ? 1 : 0;
    for (int c = 0; c < ncyc; c++) begin
      clear_inputs();
      for (int i = 0; i < NP; i++)
        for (int v = 0; v < NV; v++)
          if ($urandom % 2 == 0) begin
            in_req[i][v] = 1'b1;
            r = $urandom % 16;
            if (r == 0) in_port[i][v] = '0;
            else if (r == 1) in_port[i][v] = NP'(5'b00011 << ($urandom % 4));
            else in_port[i][v] = NP'(1 << ($urandom % NP));
            in_pri[i][v] = PW'($urandom);
          end
      for (int p = 0; p < NP; p++)
        for (int s = 0; s < cur_A; s++)
          if (outst[p].size() > 0 && $urandom % 3 == 0) begin
            in_relv[p][s]  = 1'b1;
            in_relvc[p][s] = LNV'(outst[p].pop_front());
          end else if ($urandom % 64 == 0) begin
            in_relv[p][s]  = 1'b1;
            in_relvc[p][s] = LNV'($urandom);
          end
      model_step();
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        ecnt[p] = (LNV+1)'(m_pool[p].size());
        enf[p]  = (m_pool[p].size() == 0);
      end
      chk($sformatf("rnd%0d.%0d valid", db, c), out_valid, m_pend);
      chk($sformatf("rnd%0d.%0d vc_new", db, c), out_vcnew, m_vcnew);
      chk($sformatf("rnd%0d.%0d free_count", db, c), out_cnt, ecnt);
      chk($sformatf("rnd%0d.%0d no_free_vc", db, c), out_nf, enf);
      chk($sformatf("rnd%0d.%0d err_release", db, c), out_err, m_err);
    end
    clear_inputs();
  endtask

  initial begin
    vec_t tbl[$];
    int   idx;
    logic [NP-1:0][LNV:0] full;
    for (int p = 0; p < NP; p++) full[p] = 3'd4;
    clear_inputs();

    // Reset state
    do_reset(1'b0);
    #1;
    chk("reset valid", out_valid, '0);
    chk("reset vc_new", out_vcnew, '0);
    chk("reset free_count", out_cnt, full);
    chk("reset no_free_vc", out_nf, '0);
    chk("reset err", out_err, 1'b0);

    // Single request, then an ignored multi-hot / zero port, then the same VC legal
    tbl.push_back(mk(1, 0, 20'h00001, 5'b00100, 2, 2'b00, 0, 0, 20'h00001, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 20'h00000, 5'b00100, 2, 2'b00, 0, 0, 20'h00000, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 20'h00080, 5'b00110, 1, 2'b00, 0, 0, 20'h00000, 0, 0, 4, 0));
    tbl.push_back(mk(0, 0, 20'h00080, 5'b00000, 0, 2'b00, 0, 0, 20'h00000, 0, 0, 4, 0));
    tbl.push_back(mk(0, 0, 20'h00080, 5'b00010, 1, 2'b00, 0, 0, 20'h00080, 0, 0, 3, 0));
    // All 20 to port 1: drain the pool, then release into the empty pool (no bypass), RR resumes at 4
    tbl.push_back(mk(1, 0, 20'hFFFFF, 5'b00010, 1, 2'b00, 0, 0, 20'h00001, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 20'hFFFFE, 5'b00010, 1, 2'b00, 0, 0, 20'h00002, 1, 0, 2, 0));
    tbl.push_back(mk(0, 0, 20'hFFFFC, 5'b00010, 1, 2'b00, 0, 0, 20'h00004, 2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 20'hFFFF8, 5'b00010, 1, 2'b00, 0, 0, 20'h00008, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 20'hFFFF0, 5'b00010, 1, 2'b00, 0, 0, 20'h00000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 20'hFFFF0, 5'b00010, 1, 2'b01, 2, 0, 20'h00000, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 20'hFFFF0, 5'b00010, 1, 2'b00, 0, 0, 20'h00010, 2, 0, 0, 0));
    // Full pool with a grant and a release in the same cycle: no overflow
    tbl.push_back(mk(1, 0, 20'h00001, 5'b00001, 0, 2'b01, 3, 0, 20'h00001, 0, 0, 4, 0));
    // Release to a full pool: sticky error, count stays nv
    tbl.push_back(mk(1, 0, 20'h00000, 5'b01000, 3, 2'b01, 0, 0, 20'h00000, 0, 0, 4, 1));
    tbl.push_back(mk(0, 0, 20'h00000, 5'b01000, 3, 2'b00, 0, 0, 20'h00000, 0, 0, 4, 1));
    // Two grants per cycle, then two-slot release with the second slot overflowing
    tbl.push_back(mk(1, 1, 20'h00007, 5'b00001, 0, 2'b00, 0, 0, 20'h00003, 0, 1, 2, 0));
    tbl.push_back(mk(0, 1, 20'h00004, 5'b00001, 0, 2'b00, 0, 0, 20'h00004, 2, 0, 1, 0));
    tbl.push_back(mk(0, 1, 20'h00000, 5'b00001, 0, 2'b11, 0, 1, 20'h00000, 0, 0, 3, 0));
    tbl.push_back(mk(0, 1, 20'h00000, 5'b00001, 0, 2'b11, 2, 3, 20'h00000, 0, 0, 4, 1));
    // Dynamic priority: pri 1 at flat 0, pri 3 at flats 5 and 10
    idx = tbl.size();
    tbl.push_back(mk(1, 1, 20'h00421, 5'b10000, 4, 2'b00, 0, 0, 20'h00420, 0, 1, 2, 0));
    tbl[idx].pri[0] = 2'd1; tbl[idx].pri[5] = 2'd3; tbl[idx].pri[10] = 2'd3;
    idx = tbl.size();
    tbl.push_back(mk(0, 1, 20'h00001, 5'b10000, 4, 2'b00, 0, 0, 20'h00001, 2, 0, 1, 0));
    tbl[idx].pri[0] = 2'd1;

    for (int r = 0; r < tbl.size(); r++) apply_row(tbl[r], r);

    // Reset asserted mid-grant clears outputs at once and refills the pools
    do_reset(1'b0);
    in_req[0][0]  = 1'b1;
    in_port[0][0] = 5'b00100;
    in_relv[3][0] = 1'b1;
    @(posedge clk);
    #1;
    clear_inputs();
    chk("midrst grant valid", out_valid, 20'h00001);
    chk("midrst err before", out_err, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst valid", out_valid, '0);
    chk("midrst vc_new", out_vcnew, '0);
    chk("midrst err", out_err, 1'b0);
    chk("midrst free_count", out_cnt, full);
    chk("midrst no_free_vc", out_nf, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("postrst free_count", out_cnt, full);
    chk("postrst valid", out_valid, '0);

    run_random(1'b0, 300);
    run_random(1'b1, 300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
